// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings and write-slave FSM states.
// WRAP_EN follows the AXI_WR_SLAVE_WRAP_EN build macro.
package axi_pkg;
    typedef enum logic [1:0] {FIXED, INCR, WRAP, RSVD} burst_e;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;
`ifdef AXI_WR_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
endpackage

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat address for FIXED/INCR/WRAP bursts plus wrap-length legality.
// Wrap address logic exists only when AXI_WR_SLAVE_WRAP_EN is defined.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [3:0]        len_i,
    input  burst_e            burst_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              wrap_ok_o
);
    logic [ADDR_W-1:0] incr;
    assign incr      = addr_i + (ADDR_W'(1) << size_i);
    assign wrap_ok_o = len_i inside {4'd1, 4'd3, 4'd7, 4'd15};
`ifdef AXI_WR_SLAVE_WRAP_EN
    logic [ADDR_W-1:0] mask;
    // window is (len+1) beats of 2^size bytes, aligned to its own size
    assign mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    assign next_o = burst_i == FIXED ? addr_i :
                    burst_i == WRAP  ? (addr_i & ~mask) | (incr & mask) : incr;
`else
    assign next_o = burst_i == FIXED ? addr_i : incr;
`endif
endmodule

// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI3 write-path slave storing bursts into a byte-enabled word memory.
// WRAP bursts are legal only when AXI_WR_SLAVE_WRAP_EN is defined.
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                MEM_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_W-1:0]              AWID,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [ID_W-1:0]              WID,
    input  logic [DATA_W-1:0]            WDATA,
    input  logic [DATA_W/8-1:0]          WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [ID_W-1:0]              BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_rdata
);
    localparam int SW = DATA_W / 8;
    localparam int SH = $clog2(SW);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(MEM_WORDS * SW);

    state_e            state_q, state_d;
    burst_e            burst_q, burst_d;
    logic              act_q, err_q, err_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d, nxt_addr, off;
    logic [3:0]        len_q, len_d, cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic              len_ok, in_range, burst_bad, last, beat, we;
    logic [AW-1:0]     widx;
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr_i   (addr_q),
        .size_i   (size_q),
        .len_i    (len_q),
        .burst_i  (burst_q),
        .next_o   (nxt_addr),
        .wrap_ok_o(len_ok)
    );

    assign off       = addr_q - BASE_ADDR;
    assign widx      = off[AW+SH-1:SH];
    assign in_range  = addr_q >= BASE_ADDR && {1'b0, off} < MEM_BYTES;
    assign burst_bad = burst_q == RSVD || (burst_q == WRAP && !(WRAP_EN && len_ok)) || size_q > 3'(SH);
    assign last      = cnt_q == len_q;
    assign beat      = WVALID && WREADY;
    assign we        = beat && !burst_bad && in_range && WID == id_q;

    assign AWREADY = state_q == IDLE && act_q;
    assign WREADY  = state_q == DATA;
    assign BVALID  = state_q == RESP;
    assign BID     = id_q;
    assign BRESP   = (state_q == RESP && (err_q || burst_bad)) ? SLVERR : OKAY;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (AWVALID && AWREADY) begin
                id_d    = AWID;
                addr_d  = AWADDR;
                len_d   = AWLEN;
                size_d  = AWSIZE;
                burst_d = burst_e'(AWBURST);
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = DATA;
            end
            // burst length comes from the beat counter; WLAST only flags errors
            DATA: if (beat) begin
                err_d   = err_q || !in_range || WID != id_q || WLAST != last;
                cnt_d   = cnt_q + 4'd1;
                addr_d  = nxt_addr;
                state_d = last ? RESP : DATA;
            end
            RESP: state_d = BREADY ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            burst_q <= FIXED;
            act_q   <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            act_q   <= 1'b1;
            err_q   <= err_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    // memory has no reset so its contents survive rst
    always_ff @(posedge clk)
        for (int i = 0; i < SW; i++)
            if (we && WSTRB[i]) mem_q[widx][8*i +: 8] <= WDATA[8*i +: 8];

    assign dbg_rdata = mem_q[dbg_addr];
endmodule
